// File: rtl/mem_dumper_if.sv
// Bus bundle for mem_dumper: dump request, synchronous-RAM read port and
// the valid/ready word stream. The block uses the slave view.
interface mem_dumper_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 16
);
   logic                  start;
   logic [ADDR_WIDTH-1:0] base_addr;
   logic [ADDR_WIDTH-1:0] word_count;
   logic                  abort;
   logic                  mem_read;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_read_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic [ADDR_WIDTH-1:0] out_addr;
   logic                  out_last;
   logic                  busy;
   logic                  done;

   modport slave (
      input  start, base_addr, word_count, abort, mem_read_data, out_ready,
      output mem_read, mem_addr, out_valid, out_data, out_addr, out_last, busy, done
   );

   modport master (
      output start, base_addr, word_count, abort, mem_read_data, out_ready,
      input  mem_read, mem_addr, out_valid, out_data, out_addr, out_last, busy, done
   );
endinterface

// File: rtl/mem_dumper.sv
// Reads word_count words from a synchronous RAM starting at base_addr and
// streams each one out over a valid/ready handshake, one word per 3 cycles.
module mem_dumper #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 16
) (
   input  logic        clock,
   input  logic        reset_n,
   mem_dumper_if.slave bus
);
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_READ = 3'd1,
      ST_WAIT = 3'd2,
      ST_SEND = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] ONE_A = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
   logic [ADDR_WIDTH-1:0] remaining_q, remaining_d;
   logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic                  mem_read_q, mem_read_d;
   logic                  out_valid_q, out_valid_d;
   logic                  out_last_q, out_last_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   // State, address/count and captured-word registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         cur_addr_q  <= '0;
         remaining_q <= '0;
         out_addr_q  <= '0;
         out_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         cur_addr_q  <= cur_addr_d;
         remaining_q <= remaining_d;
         out_addr_q  <= out_addr_d;
         out_data_q  <= out_data_d;
      end
   end

   // Next-state and datapath updates; abort outranks any handshake
   always_comb begin
      state_d     = state_q;
      cur_addr_d  = cur_addr_q;
      remaining_d = remaining_q;
      out_addr_d  = out_addr_q;
      out_data_d  = out_data_q;
      if ((state_q != ST_IDLE) && bus.abort) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.start && (bus.word_count != '0)) begin
                  cur_addr_d  = bus.base_addr;
                  remaining_d = bus.word_count;
                  state_d     = ST_READ;
               end else if (bus.start) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_READ: state_d = ST_WAIT;
            ST_WAIT: begin
               out_data_d = bus.mem_read_data;
               out_addr_d = cur_addr_q;
               state_d    = ST_SEND;
            end
            ST_SEND: begin
               if (bus.out_ready && (remaining_q == ONE_A)) begin
                  state_d = ST_DONE;
               end else if (bus.out_ready) begin
                  // Counter stays >= 1, so a full-range count never wraps
                  remaining_d = remaining_q - ONE_A;
                  cur_addr_d  = cur_addr_q + ONE_A;
                  state_d     = ST_READ;
               end else begin
                  state_d = ST_SEND;
               end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Output decode from the next state so every output leaves a flop
   always_comb begin
      mem_read_d  = (state_d == ST_READ);
      mem_addr_d  = (state_d == ST_READ) ? cur_addr_d : '0;
      out_valid_d = (state_d == ST_SEND);
      out_last_d  = (state_d == ST_SEND) && (remaining_d == ONE_A);
      busy_d      = (state_d != ST_IDLE);
      done_d      = (state_d == ST_DONE);
   end

   // Output registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mem_read_q  <= 1'b0;
         mem_addr_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         mem_read_q  <= mem_read_d;
         mem_addr_q  <= mem_addr_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign bus.mem_read  = mem_read_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_addr  = out_addr_q;
   assign bus.out_last  = out_last_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
endmodule

// File: tb/tb_mem_dumper.sv
// Bench for mem_dumper: table of dumps with timing expectations, hand-written
// abort/reset sequences, and random dumps checked against a word-queue model.
module tb_mem_dumper;
   logic clk;
   logic rst_n;

   mem_dumper_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus ();

   mem_dumper #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) dut (
      .clock   (clk),
      .reset_n (rst_n),
      .bus     (bus)
   );

   typedef struct {
      logic [15:0] addr;
      logic [15:0] data;
      logic        last;
   } xfer_t;

   typedef struct {
      logic [15:0] base;
      logic [15:0] cnt;
      int          mode;
      int          exp_fv;
      int          exp_fx;
      int          exp_done;
   } vec_t;

   logic [15:0] ram [0:65535];
   xfer_t       exp_q[$];
   int          vectors;
   int          miscompares;
   logic        mon_en;
   logic        done_armed;
   logic        prev_stall;
   logic [15:0] prev_data;
   logic [15:0] prev_addr;
   logic        prev_last;
   vec_t        vt[6];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous RAM: data appears the cycle after the read strobe
   always @(posedge clk) begin
      if (bus.mem_read) bus.mem_read_data <= ram[bus.mem_addr];
      else              bus.mem_read_data <= 16'hDEAD;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic ready_for(input int mode, input int k);
      case (mode)
         0:       return 1'b1;
         1:       return 1'($urandom_range(0, 1));
         default: return !((k >= 2) && (k < 7));
      endcase
   endfunction

   task automatic monitor_step();
      logic  xfer;
      xfer_t e;
      xfer = bus.out_valid && bus.out_ready && !bus.abort;
      if (prev_stall) begin
         check("hold_valid", bus.out_valid, 1);
         check("hold_data", bus.out_data, prev_data);
         check("hold_addr", bus.out_addr, prev_addr);
         check("hold_last", bus.out_last, prev_last);
      end
      if (xfer) begin
         check("xfer_expected", exp_q.size() > 0, 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("xfer_addr", bus.out_addr, e.addr);
            check("xfer_data", bus.out_data, e.data);
            check("xfer_last", bus.out_last, e.last);
         end
      end
      if (bus.mem_read) begin
         check("read_expected", exp_q.size() > 0, 1);
         if (exp_q.size() > 0) check("read_addr", bus.mem_addr, exp_q[0].addr);
         check("read_while_valid", bus.out_valid, 0);
      end else begin
         check("addr_when_no_read", bus.mem_addr, 0);
      end
      if (bus.done) begin
         check("done_words_pending", exp_q.size(), 0);
         check("done_expected", done_armed, 1);
         done_armed = 1'b0;
      end
      prev_stall = bus.out_valid && !bus.out_ready && !bus.abort && rst_n;
      prev_data  = bus.out_data;
      prev_addr  = bus.out_addr;
      prev_last  = bus.out_last;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (mon_en) monitor_step();
      end
   end

   task automatic push_words(input logic [15:0] base, input logic [15:0] cnt);
      logic [15:0] a;
      for (int i = 0; i < int'(cnt); i++) begin
         a = base + 16'(i);
         exp_q.push_back('{a, ram[a], (i == int'(cnt) - 1)});
      end
   endtask

   // Enter and leave at 1 time unit after a rising edge
   task automatic do_dump(input logic [15:0] base, input logic [15:0] cnt, input int mode,
                          input int exp_fv, input int exp_fx, input int exp_done);
      int fv;
      int fx;
      int dc;
      fv = -1; fx = -1; dc = -1;
      push_words(base, cnt);
      done_armed     = 1'b1;
      bus.start      = 1'b1;
      bus.base_addr  = base;
      bus.word_count = cnt;
      @(posedge clk); #1;
      bus.start      = 1'b0;
      bus.base_addr  = 16'($urandom);
      bus.word_count = 16'($urandom);
      for (int k = 0; k < 300; k++) begin
         bus.out_ready = ready_for(mode, k);
         @(negedge clk);
         if (bus.out_valid && (fv < 0)) fv = k;
         if (bus.out_valid && bus.out_ready && (fx < 0)) fx = k;
         if (bus.done) begin
            dc = k;
            break;
         end
         @(posedge clk); #1;
      end
      check("dump_completes", dc >= 0, 1);
      if (exp_fv != -2)   check("first_valid_cycle", fv, exp_fv);
      if (exp_fx != -2)   check("first_xfer_cycle", fx, exp_fx);
      if (exp_done != -2) check("done_cycle", dc, exp_done);
      check("busy_in_done", bus.busy, 1);
      // A start presented while in DONE must not begin another dump
      bus.start      = 1'b1;
      bus.word_count = 16'd0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(negedge clk);
      check("done_one_cycle", bus.done, 0);
      check("idle_after_done", bus.busy, 0);
      check("all_words_sent", exp_q.size(), 0);
      exp_q.delete();
      @(posedge clk); #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vectors = 0; miscompares = 0;
      mon_en = 1'b0; done_armed = 1'b0; prev_stall = 1'b0;
      prev_data = 16'd0; prev_addr = 16'd0; prev_last = 1'b0;
      rst_n = 1'b0;
      bus.start = 1'b0; bus.base_addr = 16'd0; bus.word_count = 16'd0;
      bus.abort = 1'b0; bus.out_ready = 1'b0;
      for (int i = 0; i < 65536; i++) ram[i] = 16'(i) ^ 16'h3C5A;
      ram[16'h0010] = 16'h00A1;
      ram[16'h0011] = 16'h00B2;
      ram[16'h0012] = 16'h00C3;

      vt[0] = '{16'h0010, 16'd3, 0, 2, 2, 9};
      vt[1] = '{16'h0010, 16'd3, 2, 2, 7, 14};
      vt[2] = '{16'hFFFE, 16'd3, 0, 2, 2, 9};
      vt[3] = '{16'h0000, 16'd0, 0, -1, -1, 0};
      vt[4] = '{16'h1234, 16'd1, 0, 2, 2, 3};
      vt[5] = '{16'hFFFF, 16'd2, 0, 2, 2, 6};

      repeat (3) @(negedge clk);
      check("rst_mem_read", bus.mem_read, 0);
      check("rst_mem_addr", bus.mem_addr, 0);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_data", bus.out_data, 0);
      check("rst_out_addr", bus.out_addr, 0);
      check("rst_out_last", bus.out_last, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      @(posedge clk); #1;
      rst_n  = 1'b1;
      mon_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      for (int v = 0; v < 6; v++) begin
         do_dump(vt[v].base, vt[v].cnt, vt[v].mode, vt[v].exp_fv, vt[v].exp_fx, vt[v].exp_done);
      end

      // Abort during SEND of the second word with out_ready high
      push_words(16'h0040, 16'd3);
      done_armed = 1'b1;
      bus.start = 1'b1; bus.base_addr = 16'h0040; bus.word_count = 16'd3; bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("abort_in_send", bus.out_valid, 1);
      bus.abort = 1'b1;
      @(posedge clk); #1;
      bus.abort = 1'b0;
      check("abort_busy", bus.busy, 0);
      check("abort_valid", bus.out_valid, 0);
      check("abort_done", bus.done, 0);
      check("abort_words_left", exp_q.size(), 2);
      exp_q.delete();
      done_armed = 1'b0;
      repeat (4) @(posedge clk);
      #1;

      // Reset during WAIT of the second word; a start while busy is ignored
      push_words(16'h0080, 16'd2);
      done_armed = 1'b1;
      bus.start = 1'b1; bus.base_addr = 16'h0080; bus.word_count = 16'd2; bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      bus.start = 1'b1; bus.base_addr = 16'h0900; bus.word_count = 16'd5;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("busy_before_reset", bus.busy, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("rstw_mem_read", bus.mem_read, 0);
      check("rstw_mem_addr", bus.mem_addr, 0);
      check("rstw_out_valid", bus.out_valid, 0);
      check("rstw_out_data", bus.out_data, 0);
      check("rstw_out_addr", bus.out_addr, 0);
      check("rstw_out_last", bus.out_last, 0);
      check("rstw_busy", bus.busy, 0);
      check("rstw_done", bus.done, 0);
      exp_q.delete();
      done_armed = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("idle_after_reset", bus.busy, 0);

      // Random dumps with random backpressure
      for (int r = 0; r < 25; r++) begin
         logic [15:0] rb;
         logic [15:0] rc;
         rb = 16'($urandom);
         rc = 16'($urandom_range(0, 5));
         do_dump(rb, rc, 1, (rc != 16'd0) ? 2 : -1, -2, (rc != 16'd0) ? -2 : 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
